// File: rtl/sym_cn_lut_core_pkg.sv
// Shared widths, message types and the magnitude-fold helper for the
// symmetric check-node LUT block.
package sym_cn_lut_core_pkg;

   localparam int MAG_W   = 3;                // message magnitude width
   localparam int PAGE_W  = 5;                // page address width
   localparam int MSG_W   = MAG_W + 1;        // {sign, magnitude}
   localparam int ADDR_W  = PAGE_W + 1;       // {offset, page}
   localparam int LUT_DEPTH = 1 << ADDR_W;    // entries per bank
   localparam int N_PORTS = 4;

   typedef logic [MAG_W-1:0] rank_t;

   typedef struct packed {
      logic  sign;
      rank_t rank;
   } msg_t;

   // Negative messages are stored one's-complemented, so inverting the low
   // bits yields a magnitude ordered the same way as the positive side.
   function automatic rank_t fold_mag(input logic [MSG_W-1:0] y);
      return y[MSG_W-1] ? ~y[MAG_W-1:0] : y[MAG_W-1:0];
   endfunction

endpackage

// File: rtl/cn_addr_map.sv
// Combinational fold-and-address logic for one read port: produces the
// outgoing sign and the {page, bank} LUT address from two incoming messages.
module cn_addr_map
   import sym_cn_lut_core_pkg::*;
(
   input  logic [MSG_W-1:0]  y0_i,
   input  logic [MSG_W-1:0]  y1_i,
   output logic              msb_o,
   output logic [PAGE_W-1:0] page_o,
   output logic              bank_o
);

   rank_t mag0;
   rank_t mag1;

   assign mag0 = fold_mag(y0_i);
   assign mag1 = fold_mag(y1_i);

   // Output sign is set when the two incoming signs agree.
   assign msb_o  = ~(y0_i[MSG_W-1] ^ y1_i[MSG_W-1]);
   // {page, bank} is exactly {mag0, mag1}: the LSB of mag1 picks the bank.
   assign page_o = {mag0, mag1[MAG_W-1:1]};
   assign bank_o = mag1[0];

endmodule

// File: rtl/sym_cn_lut_core.sv
// Four-port symmetric check-node LUT: fold/address, a two-bank two-offset
// rank memory with asynchronous read, and a two-stage read pipeline.
module sym_cn_lut_core
   import sym_cn_lut_core_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic [MSG_W-1:0]  y0_in_A,
   input  logic [MSG_W-1:0]  y1_in_A,
   input  logic [MSG_W-1:0]  y0_in_B,
   input  logic [MSG_W-1:0]  y1_in_B,
   input  logic [MSG_W-1:0]  y0_in_C,
   input  logic [MSG_W-1:0]  y1_in_C,
   input  logic [MSG_W-1:0]  y0_in_D,
   input  logic [MSG_W-1:0]  y1_in_D,
   input  logic              read_addr_offset,
   output logic [MSG_W-1:0]  t_c_A,
   output logic [MSG_W-1:0]  t_c_B,
   output logic [MSG_W-1:0]  t_c_C,
   output logic [MSG_W-1:0]  t_c_D,
   output logic              read_addr_offset_out,
   input  logic [MAG_W-1:0]  lut_in_bank0,
   input  logic [MAG_W-1:0]  lut_in_bank1,
   input  logic [PAGE_W-1:0] page_write_addr,
   input  logic              write_addr_offset,
   input  logic              we
);

   // Ports packed A (lowest slice) to D so the per-port logic can be generated.
   logic [N_PORTS*MSG_W-1:0] y0_flat;
   logic [N_PORTS*MSG_W-1:0] y1_flat;
   logic [N_PORTS*MSG_W-1:0] tc_flat;

   assign y0_flat = {y0_in_D, y0_in_C, y0_in_B, y0_in_A};
   assign y1_flat = {y1_in_D, y1_in_C, y1_in_B, y1_in_A};

   assign t_c_A = tc_flat[0*MSG_W +: MSG_W];
   assign t_c_B = tc_flat[1*MSG_W +: MSG_W];
   assign t_c_C = tc_flat[2*MSG_W +: MSG_W];
   assign t_c_D = tc_flat[3*MSG_W +: MSG_W];

   // LUT storage, indexed {offset, page}. Not touched by reset.
   rank_t bank0_mem [LUT_DEPTH];
   rank_t bank1_mem [LUT_DEPTH];

   // Both banks are reloaded together from the single write port.
   always_ff @(posedge clk) begin
      if (we) begin
         bank0_mem[{write_addr_offset, page_write_addr}] <= lut_in_bank0;
         bank1_mem[{write_addr_offset, page_write_addr}] <= lut_in_bank1;
      end
   end

   // The offset bit travels alongside every sample, so it is shared by all
   // ports and needs only one register per stage.
   logic off_s0_q;
   logic off_s1_q;

   // Offset pipeline, cleared on reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         off_s0_q <= 1'b0;
         off_s1_q <= 1'b0;
      end else begin
         off_s0_q <= read_addr_offset;
         off_s1_q <= off_s0_q;
      end
   end

   assign read_addr_offset_out = off_s1_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_PORTS; gi++) begin : g_port
         logic              msb_s0_d;
         logic [PAGE_W-1:0] page_s0_d;
         logic              bank_s0_d;
         logic              msb_s0_q;
         logic [PAGE_W-1:0] page_s0_q;
         logic              bank_s0_q;
         rank_t             rank_s1_d;
         rank_t             rank_s1_q;
         logic              msb_s1_q;
         msg_t              tc_msg;

         cn_addr_map u_addr_map (
            .y0_i   (y0_flat[gi*MSG_W +: MSG_W]),
            .y1_i   (y1_flat[gi*MSG_W +: MSG_W]),
            .msb_o  (msb_s0_d),
            .page_o (page_s0_d),
            .bank_o (bank_s0_d)
         );

         // Stage 0: capture folded magnitudes (as {page, bank}) and sign.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               msb_s0_q  <= 1'b0;
               page_s0_q <= '0;
               bank_s0_q <= 1'b0;
            end else begin
               msb_s0_q  <= msb_s0_d;
               page_s0_q <= page_s0_d;
               bank_s0_q <= bank_s0_d;
            end
         end

         // Asynchronous LUT read addressed by the stage-0 registers.
         always_comb begin
            rank_s1_d = bank_s0_q ? bank1_mem[{off_s0_q, page_s0_q}]
                                  : bank0_mem[{off_s0_q, page_s0_q}];
         end

         // Stage 1: capture the looked-up rank and carry the sign along.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               rank_s1_q <= '0;
               msb_s1_q  <= 1'b0;
            end else begin
               rank_s1_q <= rank_s1_d;
               msb_s1_q  <= msb_s0_q;
            end
         end

         assign tc_msg.sign = msb_s1_q;
         assign tc_msg.rank = rank_s1_q;
         assign tc_flat[gi*MSG_W +: MSG_W] = tc_msg;
      end
   endgenerate

endmodule

// File: tb/tb_sym_cn_lut_core.sv
// Directed self-checking bench for sym_cn_lut_core.
module tb_sym_cn_lut_core;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] y0_in_A, y1_in_A, y0_in_B, y1_in_B;
   logic [3:0] y0_in_C, y1_in_C, y0_in_D, y1_in_D;
   logic       read_addr_offset;
   logic [3:0] t_c_A, t_c_B, t_c_C, t_c_D;
   logic       read_addr_offset_out;
   logic [2:0] lut_in_bank0, lut_in_bank1;
   logic [4:0] page_write_addr;
   logic       write_addr_offset;
   logic       we;

   int tests = 0;
   int fails = 0;

   // Shadow copy of the LUT used by the reference model.
   logic [2:0] sh0 [64];
   logic [2:0] sh1 [64];

   logic [3:0] exp_now  [4];
   logic [3:0] exp_prev [4];
   logic       off_now, off_prev;
   logic [5:0] kk;
   logic [3:0] ya, yb;

   always #5 clk = ~clk;

   sym_cn_lut_core dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .y0_in_A              (y0_in_A),
      .y1_in_A              (y1_in_A),
      .y0_in_B              (y0_in_B),
      .y1_in_B              (y1_in_B),
      .y0_in_C              (y0_in_C),
      .y1_in_C              (y1_in_C),
      .y0_in_D              (y0_in_D),
      .y1_in_D              (y1_in_D),
      .read_addr_offset     (read_addr_offset),
      .t_c_A                (t_c_A),
      .t_c_B                (t_c_B),
      .t_c_C                (t_c_C),
      .t_c_D                (t_c_D),
      .read_addr_offset_out (read_addr_offset_out),
      .lut_in_bank0         (lut_in_bank0),
      .lut_in_bank1         (lut_in_bank1),
      .page_write_addr      (page_write_addr),
      .write_addr_offset    (write_addr_offset),
      .we                   (we)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic [3:0] a, input logic [3:0] b);
      case (p)
         0: begin y0_in_A = a; y1_in_A = b; end
         1: begin y0_in_B = a; y1_in_B = b; end
         2: begin y0_in_C = a; y1_in_C = b; end
         default: begin y0_in_D = a; y1_in_D = b; end
      endcase
   endtask

   // One write cycle; shadow LUT updated to match.
   task automatic wr(input logic off, input logic [4:0] page,
                     input logic [2:0] d0, input logic [2:0] d1);
      we = 1'b1;
      write_addr_offset = off;
      page_write_addr = page;
      lut_in_bank0 = d0;
      lut_in_bank1 = d1;
      step();
      we = 1'b0;
      sh0[{off, page}] = d0;
      sh1[{off, page}] = d1;
   endtask

   // Reference model written from the behavioural description.
   function automatic logic [3:0] model(input logic [3:0] y0, input logic [3:0] y1,
                                        input logic off);
      logic [2:0] m0, m1;
      logic [5:0] idx;
      m0 = y0[3] ? ~y0[2:0] : y0[2:0];
      m1 = y1[3] ? ~y1[2:0] : y1[2:0];
      idx = {off, m0, m1[2:1]};
      return {~(y0[3] ^ y1[3]), (m1[0] ? sh1[idx] : sh0[idx])};
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) begin
         sh0[i] = 3'b000;
         sh1[i] = 3'b000;
      end
      rstn = 1'b0;
      we = 1'b0;
      lut_in_bank0 = 3'b000;
      lut_in_bank1 = 3'b000;
      page_write_addr = 5'd0;
      write_addr_offset = 1'b0;
      read_addr_offset = 1'b1;
      y0_in_A = 4'($urandom); y1_in_A = 4'($urandom);
      y0_in_B = 4'($urandom); y1_in_B = 4'($urandom);
      y0_in_C = 4'($urandom); y1_in_C = 4'($urandom);
      y0_in_D = 4'($urandom); y1_in_D = 4'($urandom);

      // Reset held with arbitrary inputs.
      step(); step(); step();
      chk("reset_A", t_c_A, 4'b0000);
      chk("reset_B", t_c_B, 4'b0000);
      chk("reset_C", t_c_C, 4'b0000);
      chk("reset_D", t_c_D, 4'b0000);
      chk("reset_off", {3'b000, read_addr_offset_out}, 4'b0000);
      rstn = 1'b1;
      read_addr_offset = 1'b0;

      // Positive pair.
      wr(1'b0, 5'd5, 3'b101, 3'b010);
      drive(0, 4'b0001, 4'b0010);
      step(); step();
      chk("pos_pair", t_c_A, 4'b1101);

      // Sign / fold cases on port A.
      drive(0, 4'b1110, 4'b1101);
      step(); step();
      chk("fold_negneg", t_c_A, 4'b1101);
      drive(0, 4'b1110, 4'b0010);
      step(); step();
      chk("fold_negpos", t_c_A, 4'b0101);
      drive(0, 4'b0001, 4'b0011);
      step(); step();
      chk("fold_bank1", t_c_A, 4'b1010);

      // All four ports in one cycle.
      drive(0, 4'b0001, 4'b0010);
      drive(1, 4'b1110, 4'b1101);
      drive(2, 4'b1110, 4'b0010);
      drive(3, 4'b0001, 4'b0011);
      step(); step();
      chk("quad_A", t_c_A, 4'b1101);
      chk("quad_B", t_c_B, 4'b1101);
      chk("quad_C", t_c_C, 4'b0101);
      chk("quad_D", t_c_D, 4'b1010);

      // Offset separation; offset output trails input by two edges.
      wr(1'b1, 5'd5, 3'b111, 3'b000);
      drive(0, 4'b0001, 4'b0010);
      read_addr_offset = 1'b1;
      step();
      read_addr_offset = 1'b0;
      step();
      chk("off1_read", t_c_A, 4'b1111);
      chk("off1_out", {3'b000, read_addr_offset_out}, 4'b0001);
      step();
      chk("off0_read", t_c_A, 4'b1101);
      chk("off0_out", {3'b000, read_addr_offset_out}, 4'b0000);

      // we=0 gating: write data changes, memory does not.
      lut_in_bank0 = 3'b000;
      lut_in_bank1 = 3'b111;
      page_write_addr = 5'd5;
      write_addr_offset = 1'b0;
      step(); step(); step();
      chk("we0_A", t_c_A, 4'b1101);
      chk("we0_D", t_c_D, 4'b1010);

      // Write timing while streaming the same address.
      we = 1'b1;
      lut_in_bank0 = 3'b011;
      lut_in_bank1 = 3'b010;
      step();                       // write edge k
      we = 1'b0;
      sh0[{1'b0, 5'd5}] = 3'b011;
      chk("wr_edge_k_old", t_c_A, 4'b1101);
      step();                       // edge k+1
      chk("wr_edge_k1_new", t_c_A, 4'b1011);
      step();
      chk("wr_edge_k2_new", t_c_A, 4'b1011);

      // Full LUT load.
      for (int i = 0; i < 64; i++) begin
         kk = 6'(i);
         wr(kk[5], kk[4:0], 3'(i * 3 + 1), 3'(i * 5 + 2));
      end

      // Back-to-back stream of 64 distinct pairs per port, varying offset.
      off_prev = 1'b0;
      for (int p = 0; p < 4; p++) exp_prev[p] = 4'b0000;
      for (int c = 0; c <= 64; c++) begin
         off_now = 1'(c) ^ 1'(c >> 3);
         read_addr_offset = off_now;
         for (int p = 0; p < 4; p++) begin
            kk = 6'(c + p * 17);
            ya = kk[3:0];
            yb = {kk[5], kk[0], kk[4], kk[1]};
            drive(p, ya, yb);
            exp_now[p] = model(ya, yb, off_now);
         end
         step();
         if (c > 0) begin
            chk($sformatf("stream_A_%0d", c - 1), t_c_A, exp_prev[0]);
            chk($sformatf("stream_B_%0d", c - 1), t_c_B, exp_prev[1]);
            chk($sformatf("stream_C_%0d", c - 1), t_c_C, exp_prev[2]);
            chk($sformatf("stream_D_%0d", c - 1), t_c_D, exp_prev[3]);
            chk($sformatf("stream_off_%0d", c - 1), {3'b000, read_addr_offset_out},
                {3'b000, off_prev});
         end
         for (int p = 0; p < 4; p++) exp_prev[p] = exp_now[p];
         off_prev = off_now;
      end

      // Asynchronous reset mid-stream: clears between clock edges.
      read_addr_offset = 1'b1;
      step(); step();
      #1 rstn = 1'b0;
      #1;
      chk("async_rst_A", t_c_A, 4'b0000);
      chk("async_rst_B", t_c_B, 4'b0000);
      chk("async_rst_C", t_c_C, 4'b0000);
      chk("async_rst_D", t_c_D, 4'b0000);
      chk("async_rst_off", {3'b000, read_addr_offset_out}, 4'b0000);
      step();
      chk("rst_hold_A", t_c_A, 4'b0000);

      // Release and resume two edges after the first sampled input.
      rstn = 1'b1;
      read_addr_offset = 1'b1;
      drive(0, 4'b1010, 4'b0110);
      drive(1, 4'b0111, 4'b1000);
      step(); step();
      chk("resume_A", t_c_A, model(4'b1010, 4'b0110, 1'b1));
      chk("resume_B", t_c_B, model(4'b0111, 4'b1000, 1'b1));
      chk("resume_off", {3'b000, read_addr_offset_out}, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
